// File: rtl/vector_alu_sequencer_if.sv
// vector_alu_sequencer_if: issue handshake, ALU control and writeback handshake
// of the vector ALU sequencer. The slave modport is the sequencer's view; the
// master modport is the view of the issuing front end plus writeback consumer.
interface vector_alu_sequencer_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             alu_en;
  logic [4:0]       alu_op;
  logic             alu_fwd_sel;
  logic             fwd_load;
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_is_vec;
  logic             illegal;
  logic             busy;

  modport slave (
    input  in_valid, in_op, in_tag, wb_ready,
    output in_ready, alu_en, alu_op, alu_fwd_sel, fwd_load,
           wb_valid, wb_tag, wb_is_vec, illegal, busy
  );

  modport master (
    output in_valid, in_op, in_tag, wb_ready,
    input  in_ready, alu_en, alu_op, alu_fwd_sel, fwd_load,
           wb_valid, wb_tag, wb_is_vec, illegal, busy
  );
endinterface

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: issue/writeback controller for the 4-lane FP vector ALU.
// A LAT-deep tracking pipe mirrors the ALU pipeline; both advance together on
// alu_en, which drops only when a final result sits at the ALU output and the
// writeback consumer is not ready. Vsma is split into a Vsmult pass and a
// Vsadd pass that consumes the forwarded product.
// The illegal flag is registered: it pulses for one cycle in the cycle after
// an out-of-range opcode is accepted.
// Optional feature macro: VALU_SEQ_PERF_EN adds perf_issued / perf_stall.
module vector_alu_sequencer #(
  parameter int LAT   = 3,
  parameter int TAG_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  vector_alu_sequencer_if.slave        bus
`ifdef VALU_SEQ_PERF_EN
  ,
  output logic [31:0]                  perf_issued,
  output logic [31:0]                  perf_stall
`endif
);

  localparam logic [4:0] OP_VSADD  = 5'd12;
  localparam logic [4:0] OP_VSMULT = 5'd14;
  localparam logic [4:0] OP_VSMA   = 5'd15;
  localparam logic [4:0] OP_LAST   = 5'd18;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SMA_WAIT = 2'd1;
  localparam logic [1:0] ST_SMA_ADD  = 2'd2;

  // pass = 1 marks a final pass (every single-pass op and the Vsma add pass);
  // pass = 0 is the Vsma multiply pass whose result only feeds the forward reg.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [4:0]       op;
    logic             pass;
  } slot_t;

  function automatic logic op_is_vec(input logic [4:0] op);
    return (op inside {[5'd3:5'd5], [5'd10:5'd18]});
  endfunction

  slot_t            slot_q [LAT];
  slot_t            slot_d [LAT];
  logic [1:0]       state_q, state_d;
  logic [TAG_W-1:0] sma_tag_q, sma_tag_d;
  logic             illegal_q, illegal_d;

  slot_t            tail;
  slot_t            new_slot;
  logic             alu_en;
  logic             in_ready;
  logic             accept;
  logic             any_valid;
  logic [4:0]       alu_op;
  logic             alu_fwd_sel;
  logic             fwd_load;

  // Pipeline enable, issue handshake and occupancy derived from current state.
  always_comb begin
    tail      = slot_q[LAT-1];
    alu_en    = !(tail.valid && tail.pass && !bus.wb_ready);
    in_ready  = (state_q == ST_RUN) && alu_en;
    accept    = bus.in_valid && in_ready;
    any_valid = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      any_valid = any_valid | slot_q[i].valid;
    end
  end

  // Sequencer FSM: issue decode, Vsma pass sequencing and tracking-pipe update.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    sma_tag_d   = sma_tag_q;
    illegal_d   = 1'b0;
    new_slot    = '0;
    alu_op      = 5'd0;
    alu_fwd_sel = 1'b0;
    fwd_load    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (bus.in_op > OP_LAST) begin
            illegal_d = 1'b1;
          end else if (bus.in_op == OP_VSMA) begin
            new_slot  = '{valid: 1'b1, tag: bus.in_tag, op: OP_VSMA, pass: 1'b0};
            alu_op    = OP_VSMULT;
            sma_tag_d = bus.in_tag;
            state_d   = ST_SMA_WAIT;
          end else begin
            new_slot = '{valid: 1'b1, tag: bus.in_tag, op: bus.in_op, pass: 1'b1};
            alu_op   = bus.in_op;
          end
        end
      end
      ST_SMA_WAIT: begin
        // The product leaves the ALU this cycle; capture it for the add pass.
        if (tail.valid && !tail.pass && alu_en) begin
          fwd_load = 1'b1;
          state_d  = ST_SMA_ADD;
        end
      end
      ST_SMA_ADD: begin
        alu_op      = OP_VSADD;
        alu_fwd_sel = 1'b1;
        if (alu_en) begin
          new_slot = '{valid: 1'b1, tag: sma_tag_q, op: OP_VSMA, pass: 1'b1};
          state_d  = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    for (int i = 0; i < LAT; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (alu_en) begin
      slot_d[0] = new_slot;
      for (int i = 1; i < LAT; i++) begin
        slot_d[i] = slot_q[i-1];
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tracking slots are reset even though they form an array:
      // their valid bits are control state, and a reset must discard
      // in-flight ops rather than let stale entries write back.
      for (int i = 0; i < LAT; i++) begin
        slot_q[i] <= '0;
      end
      state_q   <= ST_RUN;
      sma_tag_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of its neighbour; blocking would collapse the shift.
      for (int i = 0; i < LAT; i++) begin
        slot_q[i] <= slot_d[i];
      end
      state_q   <= state_d;
      sma_tag_q <= sma_tag_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.alu_en      = alu_en;
  assign bus.alu_op      = alu_op;
  assign bus.alu_fwd_sel = alu_fwd_sel;
  assign bus.fwd_load    = fwd_load;
  assign bus.wb_valid    = tail.valid && tail.pass;
  assign bus.wb_tag      = tail.tag;
  assign bus.wb_is_vec   = op_is_vec(tail.op);
  assign bus.illegal     = illegal_q;
  assign bus.busy        = any_valid || (state_q != ST_RUN);

`ifdef VALU_SEQ_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count accepted legal instructions (Vsma once, at its first pass) and stalls.
  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (accept && (bus.in_op <= OP_LAST)) begin
      perf_issued_d = perf_issued_q + 32'd1;
    end
    if (!alu_en) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Wrapping performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// tb_vector_alu_sequencer: directed self-checking bench for vector_alu_sequencer
// (LAT=3, TAG_W=5). Inputs change 1 time unit after a rising edge; outputs are
// compared 1 time unit later, well away from the next rising edge.
// Cycle c of each scenario is the c-th cycle after the first issue cycle c=0.
module tb_vector_alu_sequencer;

  localparam int LAT   = 3;
  localparam int TAG_W = 5;

  // Opcodes by number: 2 is a scalar-destination op, 10 and 11 are
  // vector-destination ops, 15 is Vsma, 25 is out of range.
  localparam logic [4:0] OP_SCALAR = 5'd2;
  localparam logic [4:0] OP_VEC_A  = 5'd10;
  localparam logic [4:0] OP_VEC_B  = 5'd11;
  localparam logic [4:0] OP_VSMA   = 5'd15;
  localparam logic [4:0] OP_BAD    = 5'd25;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  vector_alu_sequencer_if #(.TAG_W(TAG_W)) bus ();

`ifdef VALU_SEQ_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  vector_alu_sequencer #(.LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef VALU_SEQ_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Drive the issue port, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] op, input logic [TAG_W-1:0] tag);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_tag   = tag;
    #1;
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, "_in_ready"},    32'(bus.in_ready),    32'd1);
    check({where, "_alu_en"},      32'(bus.alu_en),      32'd1);
    check({where, "_alu_op"},      32'(bus.alu_op),      32'd0);
    check({where, "_alu_fwd_sel"}, 32'(bus.alu_fwd_sel), 32'd0);
    check({where, "_fwd_load"},    32'(bus.fwd_load),    32'd0);
    check({where, "_wb_valid"},    32'(bus.wb_valid),    32'd0);
    check({where, "_wb_tag"},      32'(bus.wb_tag),      32'd0);
    check({where, "_wb_is_vec"},   32'(bus.wb_is_vec),   32'd0);
    check({where, "_illegal"},     32'(bus.illegal),     32'd0);
    check({where, "_busy"},        32'(bus.busy),        32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = 5'd0;
    bus.in_tag   = '0;
    bus.wb_ready = 1'b1;

    // Reset values while rst_n is low.
    #3;
    check_reset_outputs("rst");
    #9;
    rst_n = 1'b1;

    // Scenario 1: back-to-back vector ops tags 1,2,3 with wb_ready=1.
    adv(); drive(1'b1, OP_VEC_A, 5'd1);
    check("s1_c0_in_ready", 32'(bus.in_ready), 32'd1);
    check("s1_c0_alu_op",   32'(bus.alu_op),   32'(OP_VEC_A));
    adv(); drive(1'b1, OP_VEC_A, 5'd2);
    check("s1_c1_in_ready", 32'(bus.in_ready), 32'd1);
    check("s1_c1_wb_valid", 32'(bus.wb_valid), 32'd0);
    adv(); drive(1'b1, OP_VEC_A, 5'd3);
    check("s1_c2_in_ready", 32'(bus.in_ready), 32'd1);
    check("s1_c2_wb_valid", 32'(bus.wb_valid), 32'd0);
    adv(); drive(1'b0, 5'd0, 5'd0);
    check("s1_c3_wb_valid", 32'(bus.wb_valid),  32'd1);
    check("s1_c3_wb_tag",   32'(bus.wb_tag),    32'd1);
    check("s1_c3_wb_is_vec",32'(bus.wb_is_vec), 32'd1);
    check("s1_c3_in_ready", 32'(bus.in_ready),  32'd1);
    adv(); #1;
    check("s1_c4_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("s1_c4_wb_tag",   32'(bus.wb_tag),   32'd2);
    adv(); #1;
    check("s1_c5_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("s1_c5_wb_tag",   32'(bus.wb_tag),   32'd3);
    adv(); #1;
    check("s1_c6_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("s1_c6_busy",     32'(bus.busy),     32'd0);

    // Scenario 2: scalar op tag 7 held by wb_ready=0 for cycles 3..6; tag 8
    // waits on the issue port and is accepted in cycle 7.
    adv(); drive(1'b1, OP_SCALAR, 5'd7);
    check("s2_c0_in_ready", 32'(bus.in_ready), 32'd1);
    adv(); drive(1'b0, 5'd0, 5'd0);
    adv(); #1;
    for (int c = 3; c <= 6; c++) begin
      adv();
      bus.wb_ready = 1'b0;
      drive(1'b1, OP_SCALAR, 5'd8);
      check($sformatf("s2_c%0d_wb_valid", c),  32'(bus.wb_valid),  32'd1);
      check($sformatf("s2_c%0d_wb_tag", c),    32'(bus.wb_tag),    32'd7);
      check($sformatf("s2_c%0d_wb_is_vec", c), 32'(bus.wb_is_vec), 32'd0);
      check($sformatf("s2_c%0d_alu_en", c),    32'(bus.alu_en),    32'd0);
      check($sformatf("s2_c%0d_in_ready", c),  32'(bus.in_ready),  32'd0);
    end
    adv();
    bus.wb_ready = 1'b1;
    drive(1'b1, OP_SCALAR, 5'd8);
    check("s2_c7_in_ready", 32'(bus.in_ready), 32'd1);
    check("s2_c7_alu_en",   32'(bus.alu_en),   32'd1);
    check("s2_c7_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("s2_c7_wb_tag",   32'(bus.wb_tag),   32'd7);
    adv(); drive(1'b0, 5'd0, 5'd0);
    check("s2_c8_wb_valid", 32'(bus.wb_valid), 32'd0);
    adv(); #1;
    check("s2_c9_wb_valid", 32'(bus.wb_valid), 32'd0);
    adv(); #1;
    check("s2_c10_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("s2_c10_wb_tag",   32'(bus.wb_tag),   32'd8);
    adv(); #1;
    check("s2_c11_wb_valid", 32'(bus.wb_valid), 32'd0);

    // Scenario 3: Vsma tag 4 alone.
    adv(); drive(1'b1, OP_VSMA, 5'd4);
    check("s3_c0_alu_op",      32'(bus.alu_op),      32'd14);
    check("s3_c0_in_ready",    32'(bus.in_ready),    32'd1);
    check("s3_c0_alu_fwd_sel", 32'(bus.alu_fwd_sel), 32'd0);
    adv(); drive(1'b0, 5'd0, 5'd0);
    check("s3_c1_in_ready", 32'(bus.in_ready), 32'd0);
    check("s3_c1_busy",     32'(bus.busy),     32'd1);
    check("s3_c1_alu_op",   32'(bus.alu_op),   32'd0);
    check("s3_c1_fwd_load", 32'(bus.fwd_load), 32'd0);
    adv(); #1;
    check("s3_c2_in_ready", 32'(bus.in_ready), 32'd0);
    check("s3_c2_fwd_load", 32'(bus.fwd_load), 32'd0);
    adv(); #1;
    check("s3_c3_fwd_load", 32'(bus.fwd_load), 32'd1);
    check("s3_c3_in_ready", 32'(bus.in_ready), 32'd0);
    check("s3_c3_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("s3_c3_alu_en",   32'(bus.alu_en),   32'd1);
    adv(); #1;
    check("s3_c4_alu_op",      32'(bus.alu_op),      32'd12);
    check("s3_c4_alu_fwd_sel", 32'(bus.alu_fwd_sel), 32'd1);
    check("s3_c4_in_ready",    32'(bus.in_ready),    32'd0);
    check("s3_c4_fwd_load",    32'(bus.fwd_load),    32'd0);
    adv(); #1;
    check("s3_c5_in_ready",    32'(bus.in_ready),    32'd1);
    check("s3_c5_alu_fwd_sel", 32'(bus.alu_fwd_sel), 32'd0);
    check("s3_c5_wb_valid",    32'(bus.wb_valid),    32'd0);
    adv(); #1;
    check("s3_c6_wb_valid", 32'(bus.wb_valid), 32'd0);
    adv(); #1;
    check("s3_c7_wb_valid",  32'(bus.wb_valid),  32'd1);
    check("s3_c7_wb_tag",    32'(bus.wb_tag),    32'd4);
    check("s3_c7_wb_is_vec", 32'(bus.wb_is_vec), 32'd1);
    adv(); #1;
    check("s3_c8_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("s3_c8_busy",     32'(bus.busy),     32'd0);

    // Scenario 4: vector op tag 2, then Vsma tag 3 the next cycle.
    adv(); drive(1'b1, OP_VEC_B, 5'd2);
    check("s4_c0_in_ready", 32'(bus.in_ready), 32'd1);
    adv(); drive(1'b1, OP_VSMA, 5'd3);
    check("s4_c1_in_ready", 32'(bus.in_ready), 32'd1);
    check("s4_c1_alu_op",   32'(bus.alu_op),   32'd14);
    adv(); drive(1'b0, 5'd0, 5'd0);
    check("s4_c2_in_ready", 32'(bus.in_ready), 32'd0);
    adv(); #1;
    check("s4_c3_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("s4_c3_wb_tag",   32'(bus.wb_tag),   32'd2);
    check("s4_c3_fwd_load", 32'(bus.fwd_load), 32'd0);
    adv(); #1;
    check("s4_c4_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("s4_c4_fwd_load", 32'(bus.fwd_load), 32'd1);
    adv(); #1;
    check("s4_c5_alu_op",      32'(bus.alu_op),      32'd12);
    check("s4_c5_alu_fwd_sel", 32'(bus.alu_fwd_sel), 32'd1);
    adv(); #1;
    check("s4_c6_wb_valid", 32'(bus.wb_valid), 32'd0);
    adv(); #1;
    check("s4_c7_wb_valid", 32'(bus.wb_valid), 32'd0);
    adv(); #1;
    check("s4_c8_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("s4_c8_wb_tag",   32'(bus.wb_tag),   32'd3);
    adv(); #1;
    check("s4_c9_wb_valid", 32'(bus.wb_valid), 32'd0);

    // Scenario 5: out-of-range opcode 25 tag 9 is dropped.
    adv(); drive(1'b1, OP_BAD, 5'd9);
    check("s5_c0_in_ready", 32'(bus.in_ready), 32'd1);
    check("s5_c0_alu_op",   32'(bus.alu_op),   32'd0);
    adv(); drive(1'b0, 5'd0, 5'd0);
    check("s5_c1_illegal", 32'(bus.illegal), 32'd1);
    check("s5_c1_busy",    32'(bus.busy),    32'd0);
    adv(); #1;
    check("s5_c2_illegal", 32'(bus.illegal), 32'd0);
    check("s5_c2_busy",    32'(bus.busy),    32'd0);
    adv(); #1;
    check("s5_c3_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("s5_c3_busy",     32'(bus.busy),     32'd0);

    // Scenario 6: reset asserted mid-Vsma, then a fresh vector op tag 1.
    adv(); drive(1'b1, OP_VSMA, 5'd5);
    adv(); drive(1'b0, 5'd0, 5'd0);
    check("s6_wait_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s6_rst");
    #2;
    rst_n = 1'b1;
    adv(); drive(1'b1, OP_VEC_A, 5'd1);
    check("s6_c0_in_ready", 32'(bus.in_ready), 32'd1);
    adv(); drive(1'b0, 5'd0, 5'd0);
    adv(); #1;
    check("s6_c2_wb_valid", 32'(bus.wb_valid), 32'd0);
    adv(); #1;
    check("s6_c3_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("s6_c3_wb_tag",   32'(bus.wb_tag),   32'd1);
    adv(); #1;
    check("s6_c4_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("s6_c4_busy",     32'(bus.busy),     32'd0);

`ifdef VALU_SEQ_PERF_EN
    // Only the vector op issued after the second reset has been counted.
    check("perf_issued", perf_issued, 32'd1);
    check("perf_stall",  perf_stall,  32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
